// File: rtl/clk_divider.sv
// clk_divider: selectable integer clock divider with a free-running count,
// a registered divided clock (oCLK) and a one-cycle wrap pulse (oTick).
//
// Optional feature macro: CLK_DIV_SYNC_EN
//   defined   -> iSel and iEn pass through a two-flop synchronizer, so the
//                effective select/enable lag the pins by 2 CLK cycles.
//   undefined -> iSel and iEn are used directly (0-cycle latency).
//
// The active divisor N only changes at a wrap, so a select change in the
// middle of a period never shortens/lengthens that period or glitches oCLK.
module clk_divider #(
  parameter int unsigned DIV0  = 100000000,
  parameter int unsigned DIV1  = 50000000,
  parameter int unsigned DIV2  = 25000000,
  parameter int unsigned DIV3  = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [1:0]       iSel,
  input  logic             iEn,
  output logic             oCLK,
  output logic             oTick,
  output logic [CNT_W-1:0] oCnt
);

  // Divisors clamped to a minimum of 2 so that N/2 >= 1 and the divided
  // clock always has both a low and a high phase.
  localparam logic [CNT_W-1:0] N0 = CNT_W'((DIV0 < 2) ? 2 : DIV0);
  localparam logic [CNT_W-1:0] N1 = CNT_W'((DIV1 < 2) ? 2 : DIV1);
  localparam logic [CNT_W-1:0] N2 = CNT_W'((DIV2 < 2) ? 2 : DIV2);
  localparam logic [CNT_W-1:0] N3 = CNT_W'((DIV3 < 2) ? 2 : DIV3);

  // Effective (possibly synchronized) select and enable.
  logic [1:0] sel_eff;
  logic       en_eff;

`ifdef CLK_DIV_SYNC_EN
  logic [1:0] sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
  logic       en_s1_q,  en_s1_d,  en_s2_q,  en_s2_d;

  // Next state of the two-stage synchronizer: shift pins through.
  always_comb begin
    sel_s1_d = iSel;
    en_s1_d  = iEn;
    sel_s2_d = sel_s1_q;
    en_s2_d  = en_s1_q;
  end

  // Synchronizer stages, cleared by reset.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sel_s1_q <= 2'd0;
      sel_s2_q <= 2'd0;
      en_s1_q  <= 1'b0;
      en_s2_q  <= 1'b0;
    end else begin
      sel_s1_q <= sel_s1_d;
      sel_s2_q <= sel_s2_d;
      en_s1_q  <= en_s1_d;
      en_s2_q  <= en_s2_d;
    end
  end

  assign sel_eff = sel_s2_q;
  assign en_eff  = en_s2_q;
`else
  assign sel_eff = iSel;
  assign en_eff  = iEn;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             clk_q, clk_d;
  logic [CNT_W-1:0] sel_div;
  logic             at_last;
  logic             wrap;

  // Divisor addressed by the effective select.
  always_comb begin
    sel_div = N0;
    case (sel_eff)
      2'd0:    sel_div = N0;
      2'd1:    sel_div = N1;
      2'd2:    sel_div = N2;
      default: sel_div = N3;
    endcase
  end

  // Wrap detection: last count of the period with the enable present.
  always_comb begin
    at_last = (cnt_q == (n_q - 1'b1));
    wrap    = at_last && en_eff;
  end

  // Counter / divisor / divided-clock next state. oCLK is computed from the
  // next count and next N so the register always equals (oCnt >= N/2).
  always_comb begin
    cnt_d = cnt_q;
    n_d   = n_q;
    if (wrap) begin
      cnt_d = '0;
      n_d   = sel_div;
    end else if (en_eff) begin
      cnt_d = cnt_q + 1'b1;
    end
    clk_d = (cnt_d >= (n_d >> 1));
  end

  // Main state registers; reset aborts any period in progress.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      n_q   <= N0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      n_q   <= n_d;
      clk_q <= clk_d;
    end
  end

  assign oCnt  = cnt_q;
  assign oCLK  = clk_q;
  // Count is 0 during reset and N >= 2, so the pulse is inherently low then.
  assign oTick = wrap;

endmodule

// File: doc/clk_divider.md
CLK_DIVIDER -- requirements
Module: clk_divider

Interface
REQ-001 SHALL have parameter DIV0, default 100000000, meaning divisor when iSel=0 (1 Hz from 100 MHz).
REQ-002 SHALL have parameter DIV1, default 50000000, meaning divisor when iSel=1.
REQ-003 SHALL have parameter DIV2, default 25000000, meaning divisor when iSel=2.
REQ-004 SHALL have parameter DIV3, default 2, meaning divisor when iSel=3.
REQ-005 SHALL have parameter CNT_W, default 32, meaning width of the internal counter and oCnt.
REQ-006 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port iSel, input, 2 bits: divisor select.
REQ-009 SHALL have port iEn, input, 1 bit: count enable.
REQ-010 SHALL have port oCLK, output, 1 bit: divided clock for the downstream mod-8 counter's CLK.
REQ-011 SHALL have port oTick, output, 1 bit: one-CLK-cycle pulse at each divided-period wrap.
REQ-012 SHALL have port oCnt, output, CNT_W bits: current count value.

Function
REQ-013 SHALL hold an active divisor N; any selected divisor below 2 SHALL be clamped to 2.
REQ-014 SHALL count oCnt 0,1,...,N-1 and wrap to 0, advancing once per CLK when the effective enable is 1.
REQ-015 SHALL hold oCnt and oCLK when the effective enable is 0, and drive oTick 0.
REQ-016 SHALL drive oCLK as a register output equal to (oCnt >= N/2, integer division) in every cycle; for even N the duty is 50 %, for odd N the high phase is one cycle longer.
REQ-017 SHALL assert oTick for exactly one cycle, in the same cycle oCnt == N-1 with the effective enable at 1.
REQ-018 SHALL latch a new N from the effective select only at a wrap (oCnt == N-1 with enable 1); a select change mid-period SHALL NOT alter the current period or glitch oCLK.
REQ-019 SHALL produce its first rising edge of oCLK N/2 enabled cycles after reset release.
REQ-020 SHALL satisfy simultaneous wrap and select change: the wrap completes with the old N, and the new N applies from oCnt = 0.
REQ-021 SHALL, when enable drops in the same cycle as oCnt == N-1, suppress oTick and freeze at N-1 until enable returns, then wrap with oTick on the first enabled cycle.

Reset
REQ-022 SHALL, while rst=1, force oCnt=0, oCLK=0, oTick=0, synchronizer stages=0, and N = the divisor for iSel=0 (clamped).
REQ-023 SHALL load N from the current effective select on the first enabled wrap after release; reset asserted mid-period SHALL abort the period immediately with no oTick.

Configuration
REQ-024 SHALL recognise macro CLK_DIV_SYNC_EN.
REQ-025 SHALL, when CLK_DIV_SYNC_EN is defined, pass iSel and iEn through a two-flop synchronizer, so the effective select and enable lag the pins by 2 CLK cycles.
REQ-026 SHALL, when CLK_DIV_SYNC_EN is not defined, use iSel and iEn directly as the effective select and enable, with 0-cycle latency.

Verification (DIV0=4, DIV1=5, DIV2=2, DIV3=1, macro undefined unless noted)
REQ-027 SHALL cover: reset, iSel=0, iEn=1 -> oCnt 0,1,2,3,0...; oCLK 0,0,1,1; oTick high at oCnt=3 only.
REQ-028 SHALL cover: iSel=1, iEn=1 -> period 5; oCLK low for oCnt 0-1, high for 2-4; one oTick per 5 cycles.
REQ-029 SHALL cover: iSel switched 0->1 at oCnt=1 -> the current period finishes at 4 cycles, then 5-cycle periods; no extra oCLK edge.
REQ-030 SHALL cover: iSel=3 -> clamped N=2; oCLK toggles each cycle; oTick every 2nd cycle.
REQ-031 SHALL cover: iEn=0 at oCnt=3 for 3 cycles, then iEn=1 -> oCnt holds 3 with oTick=0, then wraps with one oTick; then rst pulsed at oCnt=2 -> oCnt=0, oCLK=0 immediately (asynchronous).
REQ-032 SHALL cover, with CLK_DIV_SYNC_EN defined: an iEn 1->0 step -> oCnt stops advancing exactly 2 cycles later.
